// File: rtl/dclab_audio_pkg.sv
// -----------------------------------------------------------------------------
// dclab_audio_pkg
//
// Shared definitions for the audio capture and playback blocks.
//   DEFAULT_WIDTH  : sample width in bits. It is also the number of bits
//                    shifted per half-frame.
//   DEFAULT_ADDR_W : external SRAM address width.
//   dac_state_t    : playback controller states.
// -----------------------------------------------------------------------------
package dclab_audio_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_ADDR_W = 18;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    WAIT_FRAME,
    RUN,
    DONE
  } dac_state_t;

endpackage : dclab_audio_pkg

// File: rtl/dac_shifter.sv
// -----------------------------------------------------------------------------
// dac_shifter
//
// WIDTH-bit shift register with parallel load. It shifts LSB first and has a
// bit counter. The load cycle already presents din[0] on dout. Each later
// clock presents the next bit. After WIDTH bits have been emitted, dout holds
// 0 until the next load.
//
// Ports:
//   clk    in   bit clock
//   reset  in   synchronous, active-high
//   clear  in   synchronous flush to the empty state (abort / end of run)
//   load   in   load din and emit din[0]
//   din    in   WIDTH-bit parallel word
//   dout   out  registered serial bit; 0 when exhausted
// -----------------------------------------------------------------------------
module dac_shifter
  import dclab_audio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BITS_AFTER_FIRST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg;
  // Number of bits still to be emitted after the one currently on dout.
  logic [CW-1:0]    left_reg;
  logic             dout_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_reg <= '0;
      left_reg  <= '0;
      dout_reg  <= 1'b0;
    end else if (load) begin
      shift_reg <= din;
      left_reg  <= BITS_AFTER_FIRST;
      dout_reg  <= din[0];
    end else if (left_reg != '0) begin
      // shift_reg[0] is already on dout, so the next bit is shift_reg[1].
      shift_reg <= shift_reg >> 1;
      dout_reg  <= shift_reg[1];
      left_reg  <= left_reg - 1'b1;
    end else begin
      dout_reg  <= 1'b0;
    end
  end

  assign dout = dout_reg;

endmodule : dac_shifter

// File: rtl/dac.sv
// -----------------------------------------------------------------------------
// dac
//
// Playback path. It reads mono samples from external SRAM, starting at
// address 0 and ending at end_addr (inclusive). Each sample is serialised
// LSB first onto DACDAT in I2S timing, one bclk after each daclrc transition.
// Every word is sent in both the left (daclrc low) and the right (daclrc high)
// half-frame.
//
// Ports:
//   bclk      in   CODEC bit clock; all logic on posedge
//   reset     in   synchronous, active-high
//   daclrc    in   CODEC DAC frame clock; low = left, high = right
//   play      in   level; high = run, low = abort / idle
//   end_addr  in   last SRAM address to play (inclusive)
//   sram_dq   in   SRAM read data
//   addr      out  SRAM address; released to Z whenever play is low
//   read      out  SRAM output-enable request
//   dacdat    out  serial data to the CODEC
//   done      out  high once the word at end_addr has played; cleared by play=0
// -----------------------------------------------------------------------------
module dac
  import dclab_audio_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int FETCH_CYCLES = 2
) (
  input  logic              bclk,
  input  logic              reset,
  input  logic              daclrc,
  input  logic              play,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [WIDTH-1:0]  sram_dq,
  output logic [ADDR_W-1:0] addr,
  output logic              read,
  output logic              dacdat,
  output logic              done
);

  localparam int FW = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;
  localparam logic [FW-1:0]     FETCH_LAST = FW'(FETCH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  dac_state_t        state_reg;
  dac_state_t        state_next;
  logic              daclrc_q;
  logic [ADDR_W-1:0] addr_cnt_reg;
  logic              read_reg;
  logic [FW-1:0]     fetch_left_reg;
  logic [WIDTH-1:0]  next_buf_reg;
  logic [WIDTH-1:0]  cur_buf_reg;
  // Set when the word now in cur_buf is the one at end_addr. The next falling
  // edge then ends the run. A flag is used because the counter cannot step
  // past the top address when end_addr is the largest address.
  logic              last_word_reg;

  // ---------------------------------------------------------------------------
  // Control strobes from the FSM
  // ---------------------------------------------------------------------------
  logic              lrc_fall;
  logic              lrc_rise;
  logic              fetch_done;
  logic              abort;
  logic              advance;
  logic              fetch_start;
  logic              cnt_inc;
  logic              sh_load;
  logic              sh_from_cur;
  logic              sh_clear;
  logic [WIDTH-1:0]  sh_din;
  logic              sh_dout;

  assign lrc_fall   = daclrc_q & ~daclrc;
  assign lrc_rise   = ~daclrc_q & daclrc;
  assign fetch_done = read_reg && (fetch_left_reg == '0);

  // ---------------------------------------------------------------------------
  // FSM next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    abort       = 1'b0;
    advance     = 1'b0;
    fetch_start = 1'b0;
    cnt_inc     = 1'b0;
    sh_load     = 1'b0;
    sh_from_cur = 1'b0;
    sh_clear    = 1'b0;

    if (!play) begin
      // Abort takes priority over any frame edge in the same cycle.
      state_next = IDLE;
      abort      = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next  = PREFETCH;
          fetch_start = 1'b1;
        end
        PREFETCH: begin
          if (fetch_done) begin
            state_next = WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          // The first falling edge both starts the run and plays word 0.
          if (lrc_fall) begin
            state_next = RUN;
            advance    = 1'b1;
          end
        end
        RUN: begin
          if (lrc_fall) begin
            if (last_word_reg) begin
              state_next = DONE;
              sh_clear   = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end else if (lrc_rise) begin
            // The right half-frame repeats the word from the left half.
            sh_load     = 1'b1;
            sh_from_cur = 1'b1;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase

      // Move on to the prefetched word and start fetching its successor.
      // The counter saturates at the top address. That word is already in
      // next_buf, so the fetch is skipped there and nothing wraps to address 0.
      if (advance) begin
        sh_load = 1'b1;
        if (addr_cnt_reg != ADDR_MAX) begin
          cnt_inc     = 1'b1;
          fetch_start = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register, edge detector, address counter and fetch sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge bclk) begin
    if (reset) begin
      state_reg      <= IDLE;
      daclrc_q       <= 1'b0;
      addr_cnt_reg   <= '0;
      read_reg       <= 1'b0;
      fetch_left_reg <= '0;
      next_buf_reg   <= '0;
      cur_buf_reg    <= '0;
      last_word_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      daclrc_q  <= daclrc;

      if (abort) begin
        addr_cnt_reg   <= '0;
        read_reg       <= 1'b0;
        fetch_left_reg <= '0;
        last_word_reg  <= 1'b0;
      end else begin
        // read is raised together with the address. The data is captured at
        // the posedge that closes the last read cycle.
        if (fetch_start) begin
          read_reg       <= 1'b1;
          fetch_left_reg <= FETCH_LAST;
        end else if (read_reg) begin
          if (fetch_left_reg == '0) begin
            read_reg     <= 1'b0;
            next_buf_reg <= sram_dq;
          end else begin
            fetch_left_reg <= fetch_left_reg - 1'b1;
          end
        end

        if (advance) begin
          cur_buf_reg   <= next_buf_reg;
          // The word entering cur_buf comes from the current counter value.
          last_word_reg <= (addr_cnt_reg >= end_addr);
        end

        if (cnt_inc) begin
          addr_cnt_reg <= addr_cnt_reg + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  assign sh_din = sh_from_cur ? cur_buf_reg : next_buf_reg;

  dac_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk   (bclk),
    .reset (reset),
    .clear (abort | sh_clear),
    .load  (sh_load),
    .din   (sh_din),
    .dout  (sh_dout)
  );

  // ---------------------------------------------------------------------------
  // Outputs. The address bus is shared with the capture block, so it is only
  // driven while playback is requested.
  // ---------------------------------------------------------------------------
  assign addr   = play ? addr_cnt_reg : {ADDR_W{1'bz}};
  assign read   = read_reg;
  assign dacdat = sh_dout;
  assign done   = (state_reg == DONE);

endmodule : dac
